// File: rtl/cla_adder_4bit.sv
// cla_adder_4bit: registered carry-lookahead adder, sum = a + b + cin.
// WIDTH must be a positive multiple of 4. Each 4-bit group has flat
// lookahead carries, and a second-level lookahead unit turns the group P/G
// into group carry-ins, so carry depth does not grow bit by bit.
// Registered group_p/group_g outputs let the block feed a wider CLA tree.
// Optional macro CLA_OVF_EN adds a registered signed-overflow output ovf.
module cla_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             group_p,
    output logic             group_g
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / 4;

    // Per-bit generate/propagate.
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;

    // Group-level generate/propagate and group carry-ins (gc[NG] is the carry-out).
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      gc;

    // Full carry vector: c[i] is the carry into bit i, c[WIDTH] the carry-out.
    logic [WIDTH:0]   c;

    // Whole-block generate, i.e. the carry-out when cin = 0.
    logic             blk_g;

    // Next-state values for the output registers.
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             gp_d;
    logic             gg_d;

    // Output registers.
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             gp_q;
    logic             gg_q;
    logic             valid_q;

`ifdef CLA_OVF_EN
    logic             ovf_d;
    logic             ovf_q;
`endif

    // AND of v[lo .. hi-1]; an empty span yields 1 so it acts as a neutral term.
    function automatic logic span_and(input logic [NG-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NG; i++) begin
            if (i >= lo && i < hi) begin
                r = r & v[i];
            end
        end
        return r;
    endfunction

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    // Per-group lookahead: group P/G and the three internal carries, all flat
    // sum-of-products driven from the group carry-in gc[k].
    for (genvar k = 0; k < NG; k++) begin : g_group
        localparam int B = 4 * k;

        assign grp_p[k] = bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_p[B];

        assign grp_g[k] = bit_g[B+3]
                        | (bit_p[B+3] & bit_g[B+2])
                        | (bit_p[B+3] & bit_p[B+2] & bit_g[B+1])
                        | (bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_g[B]);

        assign c[B]   = gc[k];

        assign c[B+1] = bit_g[B]
                      | (bit_p[B] & gc[k]);

        assign c[B+2] = bit_g[B+1]
                      | (bit_p[B+1] & bit_g[B])
                      | (bit_p[B+1] & bit_p[B] & gc[k]);

        assign c[B+3] = bit_g[B+2]
                      | (bit_p[B+2] & bit_g[B+1])
                      | (bit_p[B+2] & bit_p[B+1] & bit_g[B])
                      | (bit_p[B+2] & bit_p[B+1] & bit_p[B] & gc[k]);
    end

    assign c[WIDTH] = gc[NG];

    // Second-level lookahead: each group carry-in is a flat OR of generate
    // terms qualified by the propagates between them, never a chain of gc.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gc    = '0;
        blk_g = 1'b0;
        gc[0] = cin;
        for (int k = 1; k <= NG; k++) begin
            gc[k] = span_and(grp_p, 0, k) & cin;
            for (int j = 0; j < k; j++) begin
                gc[k] = gc[k] | (grp_g[j] & span_and(grp_p, j + 1, k));
            end
        end
        for (int j = 0; j < NG; j++) begin
            blk_g = blk_g | (grp_g[j] & span_and(grp_p, j + 1, NG));
        end
    end

    // Next-state results for the output registers.
    always_comb begin
        sum_d  = bit_p ^ c[WIDTH-1:0];
        cout_d = c[WIDTH];
        gp_d   = &bit_p;
        gg_d   = blk_g;
`ifdef CLA_OVF_EN
        ovf_d  = c[WIDTH] ^ c[WIDTH-1];
`endif
    end

    // Output registers: reset clears everything, a valid input loads a new
    // result, otherwise the previous result is held and out_valid drops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            gp_q    <= 1'b0;
            gg_q    <= 1'b0;
            valid_q <= 1'b0;
`ifdef CLA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                gp_q   <= gp_d;
                gg_q   <= gg_d;
`ifdef CLA_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign group_p   = gp_q;
    assign group_g   = gg_q;
`ifdef CLA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_4bit.sv
// Self-checking bench for cla_adder_4bit (WIDTH = 4): directed vector table,
// reset/hold/mid-stream-reset sequences, and a full 512-case sweep against
// a plain integer reference. Checks ovf as well when CLA_OVF_EN is defined.
module tb_cla_adder_4bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic [3:0] sum;
    logic       cout;
    logic       group_p;
    logic       group_g;
`ifdef CLA_OVF_EN
    logic       ovf;
`endif

    int total;
    int bad;

    cla_adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .group_p   (group_p),
        .group_g   (group_g)
`ifdef CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       gp;
        logic       gg;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one operand set, clock it in, and sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [3:0] va,
                        input logic [3:0] vb, input logic vc);
        rst      = r;
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ov, input logic [3:0] s,
                             input logic co, input logic gp, input logic gg);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".sum"},       {28'd0, sum},       {28'd0, s});
        check({tag, ".cout"},      {31'd0, cout},      {31'd0, co});
        check({tag, ".group_p"},   {31'd0, group_p},   {31'd0, gp});
        check({tag, ".group_g"},   {31'd0, group_g},   {31'd0, gg});
    endtask

    initial begin
        logic [4:0] full;
        logic [4:0] nocin;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [3:0] low3;

        total = 0;
        bad   = 0;

        //          a      b      cin   sum    cout  gp    gg    ovf
        vecs[0]  = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'h6, 4'h3, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{4'hC, 4'h3, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset held for two edges while a valid input is presented.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 4'hF, 4'h1, 1'b0);
            check_all("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef CLA_OVF_EN
            check("reset.ovf", {31'd0, ovf}, 32'd0);
`endif
        end

        // Directed table, applied back to back.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].sum, vecs[i].cout,
                      vecs[i].gp, vecs[i].gg);
`ifdef CLA_OVF_EN
            check($sformatf("vec%0d.ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
`endif
        end

        // Hold: one result, then three idle cycles with junk on the operands.
        step(1'b0, 1'b1, 4'h6, 4'h3, 1'b0);
        check_all("hold_load", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
            check_all($sformatf("hold%0d", i), 1'b0, 4'h9, 1'b0, 1'b0, 1'b0);
`ifdef CLA_OVF_EN
            check($sformatf("hold%0d.ovf", i), {31'd0, ovf}, 32'd1);
`endif
        end

        // Mid-stream reset: a valid result, then rst wins over a new valid input.
        step(1'b0, 1'b1, 4'hF, 4'h1, 1'b0);
        check_all("pre_rst", 1'b1, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'hA, 4'h5, 1'b1);
        check_all("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h2, 4'h2, 1'b1);
        check_all("post_rst", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep against integer addition.
        for (int i = 0; i < 512; i++) begin
            ra    = 4'(i);
            rb    = 4'(i >> 4);
            rc    = 1'(i >> 8);
            full  = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
            nocin = {1'b0, ra} + {1'b0, rb};
            step(1'b0, 1'b1, ra, rb, rc);
            check_all($sformatf("sweep a=%0h b=%0h c=%0b", ra, rb, rc), 1'b1,
                      full[3:0], full[4], &(ra ^ rb), nocin[4]);
`ifdef CLA_OVF_EN
            // Carry into the MSB comes from adding the low three bits.
            low3 = {1'b0, ra[2:0]} + {1'b0, rb[2:0]} + {3'd0, rc};
            check($sformatf("sweep.ovf a=%0h b=%0h c=%0b", ra, rb, rc),
                  {31'd0, ovf}, {31'd0, full[4] ^ low3[3]});
`else
            low3 = '0;
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_adder_4bit.md
Name: cla_adder_4bit

Overview:
- Registered 4-bit carry-lookahead adder: sum = a + b + cin, with carry-out and group propagate/generate outputs for cascading into wider CLA trees.
- Used as the leaf adder in datapath arithmetic where a single-cycle registered result is required.
- Carries are computed by lookahead equations, not rippled, so the combinational depth is independent of bit position.

Parameters:
- WIDTH, 4, operand width; must be a positive multiple of 4. Each 4-bit group uses full lookahead; groups chain via group P/G through a second-level lookahead unit.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies a/b/cin this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  sum/cout/group_p/group_g hold a result
- sum  output  WIDTH  registered (a+b+cin) mod 2^WIDTH
- cout  output  1  registered carry-out of the MSB
- group_p  output  1  registered AND of all bit propagates (p_i = a_i ^ b_i)
- group_g  output  1  registered block generate (carry-out assuming cin=0)

Behaviour:
- One clock; reset is synchronous and active-high. Sampled on the rising edge of clk.
- Per-bit signals: g_i = a_i & b_i and p_i = a_i ^ b_i.
- Carry equations: c0 = cin, c_{i+1} = g_i | (p_i & c_i), expanded to flat sum-of-products per 4-bit group. sum_i = p_i ^ c_i.
- Latency is 1 cycle. When in_valid=1 at edge N, the outputs show the result after edge N and out_valid=1. When in_valid=0, out_valid=0 after the edge, and sum/cout/group_p/group_g hold their previous values.
- Reset: when rst=1 at an edge, sum=0, cout=0, group_p=0, group_g=0 and out_valid=0. rst overrides in_valid in the same cycle. Asserting reset mid-stream discards the in-flight result.
- Arithmetic is unsigned and modulo 2^WIDTH; cout is bit WIDTH of the full sum.
- Boundary cases:
  - All-ones plus 1 wraps: sum=0, cout=1.
  - a ^ b all-ones with cin=1: carry propagates through every bit, sum=0, cout=1, group_p=1.
- Inputs are not registered separately; only the outputs are registered.
- No X propagation requirement beyond standard RTL semantics; a/b/cin are don't-care when in_valid=0.

Optional Feature:
- Macro CLA_OVF_EN.
- When defined: adds an output port ovf (1 bit, registered alongside sum) equal to the signed two's-complement overflow, c_WIDTH ^ c_{WIDTH-1}. ovf resets to 0 and holds when in_valid=0.
- When undefined: the ovf port and its logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and a=4'hF, b=4'h1 -> sum=0, cout=0, group_p=0, group_g=0, out_valid=0.
- a=4'b0011, b=4'b0101, cin=0, in_valid=1 -> next cycle sum=4'b1000, cout=0, out_valid=1.
- a=4'b1111, b=4'b0001, cin=0 -> sum=4'b0000, cout=1, group_g=1, group_p=0.
- Full propagate: a=4'b1010, b=4'b0101, cin=1 -> sum=4'b0000, cout=1, group_p=1, group_g=0.
- a=4'b0110, b=4'b0011, cin=0, then in_valid=0 for 3 cycles -> sum=4'b1001, cout=0 held; out_valid goes 1 then 0.
- Exhaustive sweep of all 512 combinations of a, b and cin, checked against a reference a+b+cin. With CLA_OVF_EN, also check a=4'b0111, b=4'b0001 -> ovf=1, and a=4'b1000, b=4'b1000 -> ovf=1, cout=1.
